// File: rtl/pm_pkg.sv
// ---------------------------------------------------------------------------
// pm_pkg
// Shared definitions for the multiplier back-end (product_accumulator and
// its sign-magnitude converter).
//   PROD_W     : width of a sign-magnitude product (sign + magnitude)
//   PROD_MAG_W : width of the magnitude field
//   state_e    : accumulator control states
// ---------------------------------------------------------------------------
package pm_pkg;

    localparam int PROD_W     = 31;
    localparam int PROD_MAG_W = 30;

    typedef enum logic {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } state_e;

endpackage

// File: rtl/sm_to_tc.sv
// ---------------------------------------------------------------------------
// sm_to_tc
// Purely combinational sign-magnitude to two's-complement converter.
// Parameters:
//   ACC_W    : output width (must exceed PROD_MAG_W so the magnitude fits
//              as a positive number)
// Ports:
//   prod_i   : sign-magnitude product, [PROD_W-1] = sign, rest = magnitude
//   value_o  : ACC_W-bit two's-complement value of prod_i
// ---------------------------------------------------------------------------
module sm_to_tc
    import pm_pkg::*;
#(
    parameter int ACC_W = 40
) (
    input  logic [PROD_W-1:0] prod_i,
    output logic [ACC_W-1:0]  value_o
);

    logic [ACC_W-1:0] mag_ext;
    logic             negate;

    assign mag_ext = {{(ACC_W - PROD_MAG_W){1'b0}}, prod_i[PROD_MAG_W-1:0]};

    // Negative zero (sign set, magnitude 0) is treated as plain zero.
    assign negate  = prod_i[PROD_W-1] && (prod_i[PROD_MAG_W-1:0] != '0);

    assign value_o = negate ? (-mag_ext) : mag_ext;

endmodule

// File: rtl/product_accumulator.sv
// ---------------------------------------------------------------------------
// product_accumulator
// MAC back-end: sums bursts of sign-magnitude products into a signed
// ACC_W-bit accumulator and hands the burst result to a consumer.
//
// Build option:
//   PRODUCT_ACC_SAT_EN : when defined, the accumulator clamps to the signed
//                        ACC_W range on overflow; otherwise it wraps.
//                        The sticky overflow flag behaves the same either way.
//
// Parameters:
//   ACC_W : accumulator / result width (signed, 32..64)
//   CNT_W : width of the per-burst product counter (saturating)
//
// Ports:
//   clk, rst     : clock (rising edge), asynchronous active-high reset
//   in_valid     : in_prod / in_last are valid
//   in_ready     : block accepts a product this cycle
//   in_prod      : sign-magnitude product
//   in_last      : final product of the burst
//   out_valid    : out_acc / out_count / overflow hold a completed burst
//   out_ready    : consumer accepts the result
//   out_acc      : signed burst sum
//   out_count    : number of products accepted in the burst
//   overflow     : sticky, some add in the burst left the signed range
//   dbg_state_o  : current control state
//
// Handshake: a beat transfers on a rising edge where valid && ready are both
// high; the sender keeps data stable while valid is high and ready is low.
// Ready never depends on valid. The input side is ready only in ACCUM, the
// output side is valid only in DONE, so the two sides never overlap and there
// is always at least one non-ready cycle between bursts.
// ---------------------------------------------------------------------------
module product_accumulator
    import pm_pkg::*;
#(
    parameter int ACC_W = 40,
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_acc,
    output logic [CNT_W-1:0]  out_count,
    output logic              overflow,
    output state_e            dbg_state_o
);

    state_e           state_q;
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             ovf_q;
    logic             ovf_d;

    logic [ACC_W-1:0] value;
    logic [ACC_W:0]   sum_full;
    logic             add_ovf;
    logic             accept;

`ifdef PRODUCT_ACC_SAT_EN
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W - 1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W - 1){1'b0}}};
`endif

    sm_to_tc #(
        .ACC_W (ACC_W)
    ) u_sm_to_tc (
        .prod_i  (in_prod),
        .value_o (value)
    );

    assign in_ready    = (state_q == ACCUM) && !rst;
    assign out_valid   = (state_q == DONE);
    assign out_acc     = acc_q;
    assign out_count   = cnt_q;
    assign overflow    = ovf_q;
    assign dbg_state_o = state_q;

    assign accept = in_valid && in_ready;

    always_comb begin
        // One guard bit: the true sum of two ACC_W-bit signed values always
        // fits in ACC_W+1 bits, so a disagreement between the top two bits
        // means the result is outside the ACC_W signed range.
        sum_full = {acc_q[ACC_W-1], acc_q} + {value[ACC_W-1], value};
        add_ovf  = sum_full[ACC_W] ^ sum_full[ACC_W-1];

`ifdef PRODUCT_ACC_SAT_EN
        // The guard bit carries the true sign, which picks the clamp rail.
        if (add_ovf) begin
            acc_d = sum_full[ACC_W] ? ACC_MIN : ACC_MAX;
        end else begin
            acc_d = sum_full[ACC_W-1:0];
        end
`else
        acc_d = sum_full[ACC_W-1:0];
`endif

        cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
        ovf_d = ovf_q | add_ovf;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (accept) begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_d;
                        ovf_q <= ovf_d;
                        if (in_last) begin
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    // Result registers double as the accumulator, so they
                    // hold until the consumer takes them, then clear.
                    if (out_ready) begin
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        ovf_q   <= 1'b0;
                        state_q <= ACCUM;
                    end
                end
                default: begin
                    state_q <= ACCUM;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_product_accumulator.sv
// ---------------------------------------------------------------------------
// tb_product_accumulator
// Two instances share one stimulus stream: u_main (ACC_W=40, CNT_W=8) and
// u_small (ACC_W=32, CNT_W=2). Their handshake timing is width-independent,
// so one reference model with per-width arithmetic covers both.
// ---------------------------------------------------------------------------
module tb_product_accumulator;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic        in_valid;
    logic [30:0] in_prod;
    logic        in_last;
    logic        out_ready;

    logic        in_ready_m, out_valid_m, overflow_m;
    logic [39:0] out_acc_m;
    logic [7:0]  out_count_m;
    pm_pkg::state_e dbg_state_m;

    logic        in_ready_s, out_valid_s, overflow_s;
    logic [31:0] out_acc_s;
    logic [1:0]  out_count_s;
    pm_pkg::state_e dbg_state_s;

    product_accumulator #(.ACC_W(40), .CNT_W(8)) u_main (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready_m),
        .in_prod     (in_prod),
        .in_last     (in_last),
        .out_valid   (out_valid_m),
        .out_ready   (out_ready),
        .out_acc     (out_acc_m),
        .out_count   (out_count_m),
        .overflow    (overflow_m),
        .dbg_state_o (dbg_state_m)
    );

    product_accumulator #(.ACC_W(32), .CNT_W(2)) u_small (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready_s),
        .in_prod     (in_prod),
        .in_last     (in_last),
        .out_valid   (out_valid_s),
        .out_ready   (out_ready),
        .out_acc     (out_acc_s),
        .out_count   (out_count_s),
        .overflow    (overflow_s),
        .dbg_state_o (dbg_state_s)
    );

    // ---------------- counters / check helper ----------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [39:0] acc_m;
        logic [7:0]  cnt_m;
        logic        ovf_m;
        logic [31:0] acc_s;
        logic [1:0]  cnt_s;
        logic        ovf_s;
    } exp_t;

    exp_t exp_q[$];

    longint m_acc_m = 0, m_acc_s = 0;
    int     m_cnt_m = 0, m_cnt_s = 0;
    bit     m_ovf_m = 0, m_ovf_s = 0;

    function automatic longint sm_value(input logic [30:0] p);
        longint mag;
        mag = longint'(p[29:0]);
        return p[30] ? -mag : mag;
    endfunction

    // Adds v to a w-bit signed accumulator held as a plain integer.
    function automatic void model_add(input longint acc_in, input longint v, input int w,
                                      output longint acc_out, output bit ovf);
        longint maxv, minv, t, m;
        maxv = (longint'(1) <<< (w - 1)) - 1;
        minv = -(longint'(1) <<< (w - 1));
        t    = acc_in + v;
        ovf  = (t > maxv) || (t < minv);
`ifdef PRODUCT_ACC_SAT_EN
        acc_out = (t > maxv) ? maxv : ((t < minv) ? minv : t);
`else
        m = t & ((longint'(1) <<< w) - 1);
        if (m > maxv) m = m - (longint'(1) <<< w);
        acc_out = m;
`endif
    endfunction

    always @(posedge clk or posedge rst) begin
        longint na;
        bit     no;
        exp_t   e;
        if (rst) begin
            exp_q.delete();
            m_acc_m = 0; m_acc_s = 0;
            m_cnt_m = 0; m_cnt_s = 0;
            m_ovf_m = 0; m_ovf_s = 0;
        end else if (exp_q.size() != 0) begin
            // A finished burst is waiting; inputs are not taken.
            if (out_ready) void'(exp_q.pop_front());
        end else if (in_valid) begin
            model_add(m_acc_m, sm_value(in_prod), 40, na, no);
            m_acc_m = na; m_ovf_m = m_ovf_m | no;
            model_add(m_acc_s, sm_value(in_prod), 32, na, no);
            m_acc_s = na; m_ovf_s = m_ovf_s | no;
            m_cnt_m = (m_cnt_m < 255) ? m_cnt_m + 1 : 255;
            m_cnt_s = (m_cnt_s < 3)   ? m_cnt_s + 1 : 3;
            if (in_last) begin
                e.acc_m = m_acc_m[39:0];
                e.cnt_m = m_cnt_m[7:0];
                e.ovf_m = m_ovf_m;
                e.acc_s = m_acc_s[31:0];
                e.cnt_s = m_cnt_s[1:0];
                e.ovf_s = m_ovf_s;
                exp_q.push_back(e);
                m_acc_m = 0; m_acc_s = 0;
                m_cnt_m = 0; m_cnt_s = 0;
                m_ovf_m = 0; m_ovf_s = 0;
            end
        end
    end

    // ---------------- scoreboard compare (every cycle) ----------------
    always @(negedge clk) begin
        logic exp_rdy, exp_vld;
        exp_rdy = !rst && (exp_q.size() == 0);
        exp_vld = (exp_q.size() != 0);
        chk("in_ready_m",  in_ready_m,  exp_rdy);
        chk("in_ready_s",  in_ready_s,  exp_rdy);
        chk("out_valid_m", out_valid_m, exp_vld);
        chk("out_valid_s", out_valid_s, exp_vld);
        if (exp_vld) begin
            chk("out_acc_m",   out_acc_m,   exp_q[0].acc_m);
            chk("out_count_m", out_count_m, exp_q[0].cnt_m);
            chk("overflow_m",  overflow_m,  exp_q[0].ovf_m);
            chk("out_acc_s",   out_acc_s,   exp_q[0].acc_s);
            chk("out_count_s", out_count_s, exp_q[0].cnt_s);
            chk("overflow_s",  overflow_s,  exp_q[0].ovf_s);
        end
    end

    // ---------------- driver tasks ----------------
    localparam int BEAT_BOUND = 60;

    // Present one beat and hold it until it is accepted; returns at
    // posedge+2 of the accepting edge.
    task automatic send_beat(input logic [30:0] p, input logic l);
        int n;
        bit taken;
        n = 0;
        taken = 0;
        in_valid = 1'b1;
        in_prod  = p;
        in_last  = l;
        while (!taken) begin
            @(negedge clk);
            taken = in_ready_m;
            n++;
            @(posedge clk);
            #2;
            if (!taken && n >= BEAT_BOUND) begin
                chk("beat_accept_timeout", 64'd0, 64'd1);
                taken = 1;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk);
        #2;
        out_ready = 1'b0;
    endtask

    bit rand_on = 0;

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        in_valid  = 1'b0;
        in_prod   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);

        // Reset state
        @(negedge clk);
        chk("rst_in_ready",  in_ready_m,  1'b0);
        chk("rst_out_valid", out_valid_m, 1'b0);
        chk("rst_out_acc",   out_acc_m,   40'd0);
        chk("rst_out_count", out_count_m, 8'd0);
        chk("rst_overflow",  overflow_m,  1'b0);
        chk("rst_out_acc_s", out_acc_s,   32'd0);
        @(posedge clk);
        #2 rst = 1'b0;

        // 1: 7 - 5 + 3 = 5, valid one cycle after the last beat
        send_beat(31'h0000_0007, 1'b0);
        send_beat(31'h4000_0005, 1'b0);
        send_beat(31'h0000_0003, 1'b1);
        @(negedge clk);
        chk("t1_valid",    out_valid_m, 1'b1);
        chk("t1_acc",      out_acc_m,   40'd5);
        chk("t1_count",    out_count_m, 8'd3);
        chk("t1_overflow", overflow_m,  1'b0);
        consume();

        // 2: negative zero single beat
        send_beat(31'h4000_0000, 1'b1);
        @(negedge clk);
        chk("t2_acc",   out_acc_m,   40'd0);
        chk("t2_count", out_count_m, 8'd1);
        chk("t2_acc_s", out_acc_s,   32'd0);
        consume();

        // 3: three max positives overflow the 32-bit instance only
        repeat (2) send_beat(31'h3FFF_FFFF, 1'b0);
        send_beat(31'h3FFF_FFFF, 1'b1);
        @(negedge clk);
        chk("t3_ovf_s", overflow_s, 1'b1);
`ifdef PRODUCT_ACC_SAT_EN
        chk("t3_acc_s", out_acc_s, 32'h7FFF_FFFF);
`else
        chk("t3_acc_s", out_acc_s, 32'hBFFF_FFFD);
`endif
        chk("t3_ovf_m", overflow_m, 1'b0);
        chk("t3_acc_m", out_acc_m,  40'h00_BFFF_FFFD);
        consume();

        // 5: count saturation at CNT_W=2
        repeat (4) send_beat(31'h0000_0001, 1'b0);
        send_beat(31'h0000_0001, 1'b1);
        @(negedge clk);
        chk("t5_count_s", out_count_s, 2'd3);
        chk("t5_acc_s",   out_acc_s,   32'd5);
        chk("t5_ovf_s",   overflow_s,  1'b0);
        chk("t5_count_m", out_count_m, 8'd5);
        consume();

        // 4: backpressure with upstream holding a beat through DONE
        send_beat(31'h0000_0010, 1'b0);
        send_beat(31'h4000_0004, 1'b1);
        in_valid = 1'b1;
        in_prod  = 31'h0000_0100;
        in_last  = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("t4_ready_held", in_ready_m, 1'b0);
            chk("t4_valid_held", out_valid_m, 1'b1);
            chk("t4_acc_held",   out_acc_m,  40'd12);
        end
        @(posedge clk);
        #2 out_ready = 1'b1;
        @(posedge clk);
        #2;
        @(negedge clk);
        chk("t4_ready_after", in_ready_m, 1'b1);
        @(posedge clk);
        #2;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        chk("t4_next_valid", out_valid_m, 1'b1);
        chk("t4_next_acc",   out_acc_m,   40'd256);
        chk("t4_next_count", out_count_m, 8'd1);
        consume();

        // 6: reset in the middle of a burst
        send_beat(31'h0000_0005, 1'b0);
        send_beat(31'h0000_0006, 1'b0);
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("t6_ready_rst", in_ready_m,  1'b0);
            chk("t6_valid_rst", out_valid_m, 1'b0);
            @(posedge clk);
            #2;
        end
        rst = 1'b0;
        send_beat(31'h0000_0002, 1'b1);
        @(negedge clk);
        chk("t6_acc",   out_acc_m,   40'd2);
        chk("t6_count", out_count_m, 8'd1);
        consume();

        // Random bursts with random consumer backpressure
        rand_on = 1;
        fork
            begin
                while (rand_on) begin
                    @(posedge clk);
                    #2 out_ready = 1'($urandom_range(0, 1));
                end
            end
        join_none

        for (int b = 0; b < 40; b++) begin
            int len;
            len = $urandom_range(1, 6);
            for (int i = 0; i < len; i++) begin
                logic [30:0] p;
                int gap, sel;
                gap = $urandom_range(0, 2);
                repeat (gap) begin
                    in_valid = 1'b0;
                    in_prod  = 31'($urandom);
                    in_last  = 1'($urandom_range(0, 1));
                    @(posedge clk);
                    #2;
                end
                sel = $urandom_range(0, 3);
                case (sel)
                    0:       p = 31'($urandom);
                    1:       p = 31'h3FFF_FFFF;
                    2:       p = 31'h7FFF_FFFF;
                    default: p = {1'($urandom_range(0, 1)), 30'($urandom_range(0, 1000))};
                endcase
                send_beat(p, (i == len - 1));
            end
        end

        rand_on = 0;
        repeat (2) @(posedge clk);
        #3 out_ready = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("final_idle_ready", in_ready_m, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
